serial_frame_shiftreg: RTL and testbench

// - Multi-channel, double-buffered parallel-in/serial-out framer feeding the bit-serial adders of the CIC datapath.
// - Accepts one frame (NCHAN words) per valid/ready handshake and streams it LSB-first on one serial line, channel 0 first.
// - Emits word and frame strobes so the downstream serial adder can clear its carry without its own bit counter.
// - A holding buffer lets the next frame load during shifting, giving gapless back-to-back frames.

---
 rtl/serial_frame_shiftreg_if.sv | 29 ++
 rtl/serial_frame_shiftreg.sv | 134 +++++++++++++
 tb/tb_serial_frame_shiftreg.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_shiftreg_if.sv
// Handshake and serial-output bundle for serial_frame_shiftreg.
// The master side drives frames and shift_en, and the slave side is the framer itself.
interface serial_frame_shiftreg_if #(
  parameter int WORDWIDTH = 8,
  parameter int NCHAN     = 4
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN*WORDWIDTH-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       shift_en;
  logic                       ser_out;
  logic                       ser_valid;
  logic                       ser_first;
  logic                       ser_last;
  logic [CW-1:0]              ser_chan;
  logic                       frame_end;

  modport master (
    output in_data, in_valid, shift_en,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, ser_chan, frame_end
  );

  modport slave (
    input  in_data, in_valid, shift_en,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, ser_chan, frame_end
  );
endinterface

// File: rtl/serial_frame_shiftreg.sv
// Double-buffered multi-channel parallel-in/serial-out framer. It emits words LSB-first and channel 0 first.
// Optional feature macro: SERIAL_FRAME_SIGN_EXT_EN appends EXTBITS copies of each word's MSB.
module serial_frame_shiftreg #(
  parameter int WORDWIDTH = 8,
  parameter int NCHAN     = 4,
  parameter int EXTBITS   = 2
) (
  input logic                    clk,
  input logic                    rst,
  serial_frame_shiftreg_if.slave bus
);

`ifdef SERIAL_FRAME_SIGN_EXT_EN
  localparam int L = WORDWIDTH + EXTBITS;
`else
  // EXTBITS does not contribute without sign extension.
  localparam int L = WORDWIDTH + 0 * EXTBITS;
`endif
  localparam int FW = NCHAN * WORDWIDTH;
  localparam int BW = $clog2(L);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(L - 1);
  localparam logic [BW-1:0] BIT_MSB   = BW'(WORDWIDTH - 1);
  localparam logic [CW-1:0] CHAN_LAST = CW'(NCHAN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_n;
  logic [FW-1:0] hold_buf, hold_buf_n;
  logic          hold_full, hold_full_n;
  logic [FW-1:0] sreg, sreg_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [CW-1:0] chan_cnt, chan_n;

  logic          advance;
  logic          word_end;
  logic          frame_done;
  logic          transfer;
  logic          shifting_n;

  logic          ser_out_q;
  logic          ser_valid_q;
  logic          ser_first_q;
  logic          ser_last_q;
  logic [CW-1:0] ser_chan_q;
  logic          frame_end_q;

  always_comb begin
    state_n     = state;
    hold_buf_n  = hold_buf;
    hold_full_n = hold_full;
    sreg_n      = sreg;
    bit_n       = bit_cnt;
    chan_n      = chan_cnt;

    advance    = (state == SHIFT) && bus.shift_en;
    word_end   = (bit_cnt == BIT_LAST);
    frame_done = advance && word_end && (chan_cnt == CHAN_LAST);
    transfer   = hold_full && ((state == IDLE) || frame_done);

    if (transfer) begin
      sreg_n      = hold_buf;
      hold_full_n = 1'b0;
      bit_n       = '0;
      chan_n      = '0;
      state_n     = SHIFT;
    end else if (frame_done) begin
      sreg_n  = '0;
      bit_n   = '0;
      chan_n  = '0;
      state_n = IDLE;
    end else if (advance) begin
      if (word_end) begin
        bit_n  = '0;
        chan_n = chan_cnt + 1'b1;
      end else begin
        bit_n = bit_cnt + 1'b1;
      end
      // The shifter parks on the MSB during extension bits and steps to the next word's LSB on the final bit.
      if ((bit_cnt < BIT_MSB) || word_end) begin
        sreg_n = sreg >> 1;
      end
    end

    // Accept is blocked while hold_full, so it never collides with a transfer.
    if (bus.in_valid && !hold_full) begin
      hold_buf_n  = bus.in_data;
      hold_full_n = 1'b1;
    end

    shifting_n = (state_n == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_buf    <= '0;
      hold_full   <= 1'b0;
      sreg        <= '0;
      bit_cnt     <= '0;
      chan_cnt    <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_chan_q  <= '0;
      frame_end_q <= 1'b0;
    end else begin
      state       <= state_n;
      hold_buf    <= hold_buf_n;
      hold_full   <= hold_full_n;
      sreg        <= sreg_n;
      bit_cnt     <= bit_n;
      chan_cnt    <= chan_n;
      // Outputs are decoded from the next state, so they line up with the registered counters.
      ser_out_q   <= shifting_n && sreg_n[0];
      ser_valid_q <= shifting_n;
      ser_first_q <= shifting_n && (bit_n == '0);
      ser_last_q  <= shifting_n && (bit_n == BIT_LAST);
      ser_chan_q  <= shifting_n ? chan_n : '0;
      frame_end_q <= shifting_n && (bit_n == BIT_LAST) && (chan_n == CHAN_LAST);
    end
  end

  assign bus.in_ready  = ~hold_full;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.ser_chan  = ser_chan_q;
  assign bus.frame_end = frame_end_q;

endmodule

// File: tb/tb_serial_frame_shiftreg.sv
// Scoreboard bench for serial_frame_shiftreg with NCHAN=4 and WORDWIDTH=8.
// Expected serial bits are queued at accept time and popped on every advancing output bit.
module tb_serial_frame_shiftreg;

`ifdef SERIAL_FRAME_SIGN_EXT_EN
  localparam int L = 10;
`else
  localparam int L = 8;
`endif

  typedef struct packed {
    logic       o;
    logic       f;
    logic       l;
    logic [1:0] ch;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  serial_frame_shiftreg_if #(.WORDWIDTH(8), .NCHAN(4)) bus ();

  serial_frame_shiftreg #(.WORDWIDTH(8), .NCHAN(4), .EXTBITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic push_frame(input logic [31:0] d);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < L; b++) begin
        e.o  = (b < 8) ? d[c*8 + b] : d[c*8 + 7];
        e.f  = (b == 0);
        e.l  = (b == L - 1);
        e.ch = 2'(c);
        e.fe = (b == L - 1) && (c == 3);
        sb.push_back(e);
      end
    end
  endtask

  // Scoreboard: a stalled bit is compared against the queue head but not consumed.
  always @(negedge clk) begin
    exp_t act;
    if (!rst && bus.ser_valid) begin
      act = {bus.ser_out, bus.ser_first, bus.ser_last, bus.ser_chan, bus.frame_end};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_bit: got unexpected bit %b, want no output (queue empty)", act);
      end else begin
        if (act !== sb[0]) begin
          n_err++;
          $display("FAIL sb_bit: got %b want %b (out,first,last,chan,fe) at %0t", act, sb[0], $time);
        end
        if (bus.shift_en) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int nf, input logic [31:0] f0, input logic [31:0] f1,
                            input logic [31:0] f2, output int acc0, output int acc1,
                            output int acc2, output int fe0, output int nvalid, output int falls);
    logic [31:0] fr[3];
    int   idx;
    logic go;
    logic was_valid;
    fr[0] = f0; fr[1] = f1; fr[2] = f2;
    idx = 0; go = 1'b0; was_valid = 1'b0;
    acc0 = -1; acc1 = -1; acc2 = -1; fe0 = -1; nvalid = 0; falls = 0;
    bus.shift_en = 1'b1;
    bus.in_data  = fr[0];
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (go) begin
        idx++;
        if (idx < nf) bus.in_data = fr[idx];
        else bus.in_valid = 1'b0;
      end
      if (bus.ser_valid) begin
        nvalid++;
        if (bus.frame_end && fe0 < 0) fe0 = cyc;
      end
      if (was_valid && !bus.ser_valid) falls++;
      was_valid = bus.ser_valid;
      go = bus.in_valid && bus.in_ready;
      if (go) begin
        push_frame(bus.in_data);
        if (idx == 0) acc0 = cyc;
        else if (idx == 1) acc1 = cyc;
        else acc2 = cyc;
      end
      if (idx >= nf && !go && nvalid > 0 && !bus.ser_valid) break;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.ser_out !== 1'b0)   begin n_err++; $display("FAIL rst_ser_out: got %b want 0", bus.ser_out); end
    n_cmp++; if (bus.ser_valid !== 1'b0) begin n_err++; $display("FAIL rst_ser_valid: got %b want 0", bus.ser_valid); end
    n_cmp++; if (bus.ser_first !== 1'b0) begin n_err++; $display("FAIL rst_ser_first: got %b want 0", bus.ser_first); end
    n_cmp++; if (bus.ser_last !== 1'b0)  begin n_err++; $display("FAIL rst_ser_last: got %b want 0", bus.ser_last); end
    n_cmp++; if (bus.ser_chan !== 2'd0)  begin n_err++; $display("FAIL rst_ser_chan: got %0d want 0", bus.ser_chan); end
    n_cmp++; if (bus.frame_end !== 1'b0) begin n_err++; $display("FAIL rst_frame_end: got %b want 0", bus.frame_end); end
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    bus.shift_en = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.ser_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_output: got %b want 0", bus.ser_valid); end
  endtask

  task automatic test_single();
    int nvalid, nfirst, nfe;
    logic [15:0] ch0;
    nvalid = 0; nfirst = 0; nfe = 0; ch0 = '0;
    bus.shift_en = 1'b1;
    bus.in_data  = 32'h8001_7F03;
    bus.in_valid = 1'b1;
    push_frame(bus.in_data);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0)  begin n_err++; $display("FAIL single_ready_after_accept: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.ser_valid !== 1'b0) begin n_err++; $display("FAIL single_latency_early: got %b want 0", bus.ser_valid); end
    tick();
    n_cmp++; if (bus.ser_valid !== 1'b1) begin n_err++; $display("FAIL single_latency_start: got %b want 1", bus.ser_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL single_ready_after_xfer: got %b want 1", bus.in_ready); end
    for (int i = 0; i < 60 && bus.ser_valid; i++) begin
      if (nvalid < L) ch0[nvalid] = bus.ser_out;
      nvalid++;
      if (bus.ser_first) nfirst++;
      if (bus.frame_end) nfe++;
      tick();
    end
    n_cmp++; if (nvalid != 4 * L) begin n_err++; $display("FAIL single_length: got %0d want %0d", nvalid, 4 * L); end
    n_cmp++; if (nfirst != 4)     begin n_err++; $display("FAIL single_first_count: got %0d want 4", nfirst); end
    n_cmp++; if (nfe != 1)        begin n_err++; $display("FAIL single_frame_end_count: got %0d want 1", nfe); end
    n_cmp++; if (ch0 !== 16'h0003) begin n_err++; $display("FAIL single_ch0_bits: got %h want 0003", ch0); end
    n_cmp++; if (sb.size() != 0)  begin n_err++; $display("FAIL single_sb_left: got %0d want 0", sb.size()); end
    n_cmp++; if (bus.ser_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_after: got %b want 0", bus.ser_valid); end
  endtask

  task automatic test_stall();
    logic [4:0] snap;
    logic [4:0] now;
    int nvalid;
    nvalid = 0;
    bus.shift_en = 1'b1;
    bus.in_data  = 32'hC35A_96E1;
    bus.in_valid = 1'b1;
    push_frame(bus.in_data);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    snap = {bus.ser_out, bus.ser_chan, bus.ser_first, bus.ser_last};
    bus.shift_en = 1'b0;
    bus.in_data  = 32'h1E2D_3C4B;
    bus.in_valid = 1'b1;
    push_frame(bus.in_data);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_accept: got in_ready %b want 0", bus.in_ready); end
      end
      now = {bus.ser_out, bus.ser_chan, bus.ser_first, bus.ser_last};
      n_cmp++; if (now !== snap) begin n_err++; $display("FAIL stall_frozen: got %b want %b", now, snap); end
    end
    bus.shift_en = 1'b1;
    for (int i = 0; i < 200 && bus.ser_valid; i++) begin
      nvalid++;
      tick();
    end
    n_cmp++; if (nvalid != 8 * L - 9) begin n_err++; $display("FAIL stall_remaining: got %0d want %0d", nvalid, 8 * L - 9); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, fe0, nv, falls;
    run_stream(2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, a0, a1, a2, fe0, nv, falls);
    n_cmp++; if (a1 - a0 != 2)    begin n_err++; $display("FAIL b2b_second_accept: got %0d want 2", a1 - a0); end
    n_cmp++; if (nv != 8 * L)     begin n_err++; $display("FAIL b2b_length: got %0d want %0d", nv, 8 * L); end
    n_cmp++; if (falls != 1)      begin n_err++; $display("FAIL b2b_gapless: got %0d falls want 1", falls); end
    n_cmp++; if (sb.size() != 0)  begin n_err++; $display("FAIL b2b_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int a0, a1, a2, fe0, nv, falls;
    run_stream(3, 32'hFFFF_0000, 32'h0F0F_F0F0, 32'hAAAA_5555, a0, a1, a2, fe0, nv, falls);
    n_cmp++; if (fe0 != a0 + 1 + 4 * L) begin n_err++; $display("FAIL bp_first_frame_end: got %0d want %0d", fe0, a0 + 1 + 4 * L); end
    n_cmp++; if (a2 != fe0 + 1)   begin n_err++; $display("FAIL bp_third_accept: got %0d want %0d", a2, fe0 + 1); end
    n_cmp++; if (nv != 12 * L)    begin n_err++; $display("FAIL bp_length: got %0d want %0d", nv, 12 * L); end
    n_cmp++; if (falls != 1)      begin n_err++; $display("FAIL bp_gapless: got %0d falls want 1", falls); end
    n_cmp++; if (sb.size() != 0)  begin n_err++; $display("FAIL bp_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    nvalid = 0;
    bus.shift_en = 1'b1;
    bus.in_data  = 32'hA5C3_3C5A;
    bus.in_valid = 1'b1;
    push_frame(bus.in_data);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.in_data  = 32'h7777_8888;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (12) tick();
    n_cmp++; if (bus.ser_valid !== 1'b1) begin n_err++; $display("FAIL rmid_active: got %b want 1", bus.ser_valid); end
    n_cmp++; if (bus.in_ready !== 1'b0)  begin n_err++; $display("FAIL rmid_hold_full: got %b want 0", bus.in_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.ser_valid !== 1'b0) begin n_err++; $display("FAIL rmid_ser_valid: got %b want 0", bus.ser_valid); end
    n_cmp++; if (bus.ser_out !== 1'b0)   begin n_err++; $display("FAIL rmid_ser_out: got %b want 0", bus.ser_out); end
    n_cmp++; if ({bus.ser_first, bus.ser_last, bus.frame_end} !== 3'b000)
      begin n_err++; $display("FAIL rmid_strobes: got %b want 000", {bus.ser_first, bus.ser_last, bus.frame_end}); end
    n_cmp++; if (bus.ser_chan !== 2'd0)  begin n_err++; $display("FAIL rmid_ser_chan: got %0d want 0", bus.ser_chan); end
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
    tick();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.ser_valid) nvalid++;
    end
    n_cmp++; if (nvalid != 0)           begin n_err++; $display("FAIL rmid_no_more_bits: got %0d want 0", nvalid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_hold_discarded: got %b want 1", bus.in_ready); end
  endtask

`ifdef SERIAL_FRAME_SIGN_EXT_EN
  task automatic test_sign_ext();
    int nvalid, last_pos;
    logic [9:0] ch0;
    nvalid = 0; last_pos = -1; ch0 = '0;
    bus.shift_en = 1'b1;
    bus.in_data  = 32'h0000_0081;
    bus.in_valid = 1'b1;
    push_frame(bus.in_data);
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 80 && bus.ser_valid; i++) begin
      if (nvalid < 10) ch0[nvalid] = bus.ser_out;
      if (bus.ser_last && last_pos < 0) last_pos = nvalid;
      nvalid++;
      tick();
    end
    n_cmp++; if (ch0 !== 10'h381) begin n_err++; $display("FAIL sext_ch0_bits: got %h want 381", ch0); end
    n_cmp++; if (last_pos != 9)   begin n_err++; $display("FAIL sext_last_pos: got %0d want 9", last_pos); end
    n_cmp++; if (nvalid != 40)    begin n_err++; $display("FAIL sext_length: got %0d want 40", nvalid); end
  endtask
`endif

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.shift_en = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_FRAME_SIGN_EXT_EN
    test_sign_ext();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
